// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the rv32 memory stage: branch ops, access widths, request FSM states.
// Optional feature macro used by this slice: RV32_MEM_MISALIGNED_TRAP_EN.
package rv32_mem_pkg;

    localparam logic [1:0] RV32_BRANCH_OP_NEVER    = 2'd0;
    localparam logic [1:0] RV32_BRANCH_OP_ZERO     = 2'd1;
    localparam logic [1:0] RV32_BRANCH_OP_NON_ZERO = 2'd2;
    localparam logic [1:0] RV32_BRANCH_OP_ALWAYS   = 2'd3;

    localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'd1;
    localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'd2;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    // Byte offset within the word after dropping address bits finer than the access size.
    function automatic logic [1:0] align_offset(input logic [1:0] width, input logic [1:0] addr_lo);
        case (width)
            RV32_MEM_WIDTH_BYTE: align_offset = addr_lo;
            RV32_MEM_WIDTH_HALF: align_offset = {addr_lo[1], 1'b0};
            default:             align_offset = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rv32_mem_align.sv
// Combinational byte-lane logic: store mask/replication and load extract/extend.
// Misaligned accesses are aligned down to the access size.
module rv32_mem_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  width,
    input  logic        zero_extend,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_value,
    input  logic [31:0] load_raw,
    output logic [3:0]  write_mask,
    output logic [31:0] write_value,
    output logic [31:0] load_value
);

    logic [1:0]  offset;
    logic [31:0] shifted;

    assign offset  = align_offset(width, addr_lo);
    assign shifted = load_raw >> {offset, 3'b000};

    always_comb begin
        write_mask = 4'b1111;
        case (width)
            RV32_MEM_WIDTH_BYTE: write_mask = 4'b0001 << offset;
            RV32_MEM_WIDTH_HALF: write_mask = 4'b0011 << offset;
            default:             write_mask = 4'b1111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign write_value[gi*8 +: 8] =
                (width == RV32_MEM_WIDTH_BYTE) ? store_value[7:0] :
                (width == RV32_MEM_WIDTH_HALF) ? store_value[(gi % 2)*8 +: 8] :
                                                 store_value[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        load_value = load_raw;
        case (width)
            RV32_MEM_WIDTH_BYTE: load_value = zero_extend ? {24'b0, shifted[7:0]}
                                                          : {{24{shifted[7]}}, shifted[7:0]};
            RV32_MEM_WIDTH_HALF: load_value = zero_extend ? {16'b0, shifted[15:0]}
                                                          : {{16{shifted[15]}}, shifted[15:0]};
            default:             load_value = load_raw;
        endcase
    end

endmodule

// File: rtl/rv32_mem.sv
// rv32 memory/branch-resolution stage: data bus requests, load extend, branch redirect.
// Optional RV32_MEM_MISALIGNED_TRAP_EN adds misaligned_out and suppresses misaligned requests.
module rv32_mem
    import rv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        branch_predicted_taken_in,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_zero_extend_in,
    input  logic        mem_fence_in,
    input  logic        rd_write_in,
    input  logic [1:0]  mem_width_in,
    input  logic [1:0]  branch_op_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    input  logic [31:0] branch_pc_in,
    output logic [31:0] data_address_out,
    output logic        data_read_out,
    output logic        data_write_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,
    output logic        mem_stall_out,
    output logic        branch_mispredicted_out,
    output logic [31:0] branch_pc_out,
    output logic        fence_out,
`ifdef RV32_MEM_MISALIGNED_TRAP_EN
    output logic        misaligned_out,
`endif
    output logic        valid_out,
    output logic        rd_write_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rd_value_out
);

    mem_state_t  state_reg, state_next;
    logic        op_read_reg, op_write_reg, killed_reg;
    logic [31:0] load_data_reg;

    logic        live, mem_op, misaligned, request;
    logic        strobe_read, strobe_write, busy;
    logic        taken, wb_valid;
    logic [3:0]  mask;
    logic [31:0] load_raw, load_value, rd_value;

    assign live   = valid_in & ~flush_in;
    assign mem_op = mem_read_in | mem_write_in;

`ifdef RV32_MEM_MISALIGNED_TRAP_EN
    assign misaligned = live & mem_op & (state_reg == MEM_IDLE) &
                        (((mem_width_in == RV32_MEM_WIDTH_HALF) & result_in[0]) |
                         ((mem_width_in == RV32_MEM_WIDTH_WORD) & (result_in[1:0] != 2'b00)));
    assign misaligned_out = misaligned & ~stall_in;
`else
    assign misaligned = 1'b0;
`endif

    // Reset gates the strobes so an outstanding transaction drops in the reset cycle itself.
    assign request      = ~reset & live & mem_op & (state_reg == MEM_IDLE) & ~misaligned;
    assign busy         = ~reset & (state_reg == MEM_BUSY);
    assign strobe_read  = request ? mem_read_in  : (busy & op_read_reg);
    assign strobe_write = request ? mem_write_in : (busy & op_write_reg);

    assign data_address_out    = {result_in[31:2], 2'b00};
    assign data_read_out       = strobe_read;
    assign data_write_out      = strobe_write;
    assign data_write_mask_out = strobe_write ? mask : 4'b0000;
    assign mem_stall_out       = (strobe_read | strobe_write) & ~data_ready_in;

    assign load_raw = (state_reg == MEM_DONE) ? load_data_reg : data_read_value_in;

    rv32_mem_align u_align (
        .width       (mem_width_in),
        .zero_extend (mem_zero_extend_in),
        .addr_lo     (result_in[1:0]),
        .store_value (rs2_value_in),
        .load_raw    (load_raw),
        .write_mask  (mask),
        .write_value (data_write_value_out),
        .load_value  (load_value)
    );

    // A completion while stalled parks in DONE so the request is not issued again.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MEM_IDLE: if (request) begin
                if (!data_ready_in)  state_next = MEM_BUSY;
                else if (stall_in)   state_next = MEM_DONE;
            end
            MEM_BUSY: if (data_ready_in) state_next = stall_in ? MEM_DONE : MEM_IDLE;
            MEM_DONE: if (!stall_in)     state_next = MEM_IDLE;
            default:  state_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= MEM_IDLE;
            op_read_reg   <= 1'b0;
            op_write_reg  <= 1'b0;
            killed_reg    <= 1'b0;
            load_data_reg <= 32'b0;
        end else begin
            state_reg <= state_next;
            if (request) begin
                op_read_reg  <= mem_read_in;
                op_write_reg <= mem_write_in;
            end
            if (state_next == MEM_IDLE)
                killed_reg <= 1'b0;
            else if (flush_in && state_reg != MEM_IDLE)
                killed_reg <= 1'b1;
            if (strobe_read && data_ready_in)
                load_data_reg <= data_read_value_in;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (branch_op_in)
            RV32_BRANCH_OP_ALWAYS:   taken = 1'b1;
            RV32_BRANCH_OP_ZERO:     taken = (result_in == 32'b0);
            RV32_BRANCH_OP_NON_ZERO: taken = (result_in != 32'b0);
            default:                 taken = 1'b0;
        endcase
    end

    assign branch_mispredicted_out = live & (taken != branch_predicted_taken_in) & ~mem_stall_out;
    assign branch_pc_out           = branch_pc_in;
    assign fence_out               = live & mem_fence_in & ~stall_in;

    assign rd_value = mem_read_in ? load_value : result_in;
    assign wb_valid = live & ~killed_reg & ~misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out    <= 1'b0;
            rd_write_out <= 1'b0;
            rd_out       <= 5'b0;
            rd_value_out <= 32'b0;
        end else if (mem_stall_out || flush_in) begin
            valid_out    <= 1'b0;
            rd_write_out <= 1'b0;
        end else if (!stall_in) begin
            valid_out    <= wb_valid;
            rd_write_out <= wb_valid & rd_write_in;
            rd_out       <= rd_in;
            rd_value_out <= rd_value;
        end
    end

endmodule

// File: tb/tb_rv32_mem.sv
// Directed self-checking bench for rv32_mem: stores, loads, wait states, stalled completion,
// branch resolution, fence, flush and reset while a request is outstanding.
module tb_rv32_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in, flush_in, branch_predicted_taken_in, valid_in;
    logic        mem_read_in, mem_write_in, mem_zero_extend_in, mem_fence_in, rd_write_in;
    logic [1:0]  mem_width_in, branch_op_in;
    logic [4:0]  rd_in;
    logic [31:0] result_in, rs2_value_in, branch_pc_in;
    logic [31:0] data_address_out;
    logic        data_read_out, data_write_out;
    logic [3:0]  data_write_mask_out;
    logic [31:0] data_write_value_out;
    logic [31:0] data_read_value_in;
    logic        data_ready_in;
    logic        mem_stall_out, branch_mispredicted_out, fence_out;
    logic [31:0] branch_pc_out;
`ifdef RV32_MEM_MISALIGNED_TRAP_EN
    logic        misaligned_out;
`endif
    logic        valid_out, rd_write_out;
    logic [4:0]  rd_out;
    logic [31:0] rd_value_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_mem dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .branch_predicted_taken_in(branch_predicted_taken_in), .valid_in(valid_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_zero_extend_in(mem_zero_extend_in), .mem_fence_in(mem_fence_in),
        .rd_write_in(rd_write_in), .mem_width_in(mem_width_in), .branch_op_in(branch_op_in),
        .rd_in(rd_in), .result_in(result_in), .rs2_value_in(rs2_value_in),
        .branch_pc_in(branch_pc_in), .data_address_out(data_address_out),
        .data_read_out(data_read_out), .data_write_out(data_write_out),
        .data_write_mask_out(data_write_mask_out), .data_write_value_out(data_write_value_out),
        .data_read_value_in(data_read_value_in), .data_ready_in(data_ready_in),
        .mem_stall_out(mem_stall_out), .branch_mispredicted_out(branch_mispredicted_out),
        .branch_pc_out(branch_pc_out), .fence_out(fence_out),
`ifdef RV32_MEM_MISALIGNED_TRAP_EN
        .misaligned_out(misaligned_out),
`endif
        .valid_out(valid_out), .rd_write_out(rd_write_out), .rd_out(rd_out),
        .rd_value_out(rd_value_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_in = 0; flush_in = 0; branch_predicted_taken_in = 0; valid_in = 0;
        mem_read_in = 0; mem_write_in = 0; mem_zero_extend_in = 0; mem_fence_in = 0;
        rd_write_in = 0; mem_width_in = 2'd2; branch_op_in = 2'd0; rd_in = 0;
        result_in = 0; rs2_value_in = 0; branch_pc_in = 0;
        data_read_value_in = 0; data_ready_in = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        $display("txn reset");
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
        checks++; if (rd_write_out !== 1'b0) begin errors++; $display("FAIL reset_rd_write got %b exp 0", rd_write_out); end
        checks++; if (rd_value_out !== 32'h0) begin errors++; $display("FAIL reset_rd_value got %h exp 0", rd_value_out); end
        checks++; if ({data_read_out, data_write_out} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {data_read_out, data_write_out}); end
        reset = 0;
        step();
    endtask

    task automatic do_store(input logic [1:0] w, input logic [31:0] addr, input logic [31:0] val,
                            input logic [3:0] exp_mask, input logic [31:0] exp_val);
        idle_inputs();
        valid_in = 1; mem_write_in = 1; mem_width_in = w; result_in = addr;
        rs2_value_in = val; data_ready_in = 1; rd_in = 5'd7;
        mid();
        $display("txn store w=%0d addr=%h val=%h mask=%b wval=%h", w, addr, val, data_write_mask_out, data_write_value_out);
        checks++; if (data_write_out !== 1'b1) begin errors++; $display("FAIL store_strobe got %b exp 1", data_write_out); end
        checks++; if (data_write_mask_out !== exp_mask) begin errors++; $display("FAIL store_mask got %b exp %b", data_write_mask_out, exp_mask); end
        checks++; if (data_write_value_out !== exp_val) begin errors++; $display("FAIL store_value got %h exp %h", data_write_value_out, exp_val); end
        checks++; if (data_address_out !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL store_addr got %h exp %h", data_address_out, {addr[31:2], 2'b00}); end
        checks++; if (mem_stall_out !== 1'b0) begin errors++; $display("FAIL store_stall got %b exp 0", mem_stall_out); end
        step();
        checks++; if ({valid_out, rd_write_out} !== 2'b10) begin errors++; $display("FAIL store_wb got %b exp 10", {valid_out, rd_write_out}); end
    endtask

    task automatic test_store();
        do_store(2'd2, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_store(2'd0, 32'h0000_1002, 32'h1234_56AB, 4'b0100, 32'hABAB_ABAB);
        do_store(2'd1, 32'h0000_1002, 32'hFFFF_1234, 4'b1100, 32'h1234_1234);
    endtask

    task automatic do_load(input logic [1:0] w, input logic zext, input logic [31:0] addr,
                           input logic [31:0] raw, input logic [31:0] exp_val);
        idle_inputs();
        valid_in = 1; mem_read_in = 1; rd_write_in = 1; rd_in = 5'd5; mem_width_in = w;
        mem_zero_extend_in = zext; result_in = addr; data_read_value_in = raw; data_ready_in = 1;
        mid();
        checks++; if (data_read_out !== 1'b1) begin errors++; $display("FAIL load_strobe got %b exp 1", data_read_out); end
        step();
        $display("txn load w=%0d zext=%0d addr=%h raw=%h rd_value=%h", w, zext, addr, raw, rd_value_out);
        checks++; if (rd_value_out !== exp_val) begin errors++; $display("FAIL load_value got %h exp %h", rd_value_out, exp_val); end
        checks++; if ({valid_out, rd_write_out, rd_out} !== {2'b11, 5'd5}) begin errors++; $display("FAIL load_wb got %b exp 1100101", {valid_out, rd_write_out, rd_out}); end
    endtask

    task automatic test_load();
        do_load(2'd0, 1'b0, 32'h0000_1003, 32'h8000_0000, 32'hFFFF_FF80);
        do_load(2'd0, 1'b1, 32'h0000_1003, 32'h8000_0000, 32'h0000_0080);
        do_load(2'd1, 1'b0, 32'h0000_1002, 32'h8001_0000, 32'hFFFF_8001);
        do_load(2'd1, 1'b1, 32'h0000_1002, 32'h8001_0000, 32'h0000_8001);
        do_load(2'd2, 1'b0, 32'h0000_1004, 32'h1234_5678, 32'h1234_5678);
    endtask

    task automatic test_passthrough();
        idle_inputs();
        valid_in = 1; rd_write_in = 1; rd_in = 5'd9; result_in = 32'h0000_0055;
        step();
        $display("txn alu result=%h rd_value=%h", result_in, rd_value_out);
        checks++; if ({valid_out, rd_write_out, rd_value_out} !== {2'b11, 32'h55}) begin errors++; $display("FAIL alu_wb got %b/%h exp 11/00000055", {valid_out, rd_write_out}, rd_value_out); end
        checks++; if (data_read_out !== 1'b0) begin errors++; $display("FAIL alu_no_strobe got %b exp 0", data_read_out); end
    endtask

    task automatic test_wait_states();
        idle_inputs();
        valid_in = 1; mem_read_in = 1; rd_write_in = 1; rd_in = 5'd3; result_in = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++; if ({mem_stall_out, data_read_out} !== 2'b11) begin errors++; $display("FAIL wait_stall%0d got %b exp 11", i, {mem_stall_out, data_read_out}); end
            step();
            checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL wait_bubble%0d got %b exp 0", i, valid_out); end
        end
        data_ready_in = 1; data_read_value_in = 32'h1234_5678;
        mid();
        checks++; if ({mem_stall_out, data_read_out} !== 2'b01) begin errors++; $display("FAIL wait_done got %b exp 01", {mem_stall_out, data_read_out}); end
        step();
        $display("txn wait_load addr=%h rd_value=%h", result_in, rd_value_out);
        checks++; if ({valid_out, rd_value_out} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL wait_wb got %b/%h exp 1/12345678", valid_out, rd_value_out); end
        idle_inputs();
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL wait_single_wb got %b exp 0", valid_out); end
    endtask

    task automatic test_stall_done();
        idle_inputs();
        valid_in = 1; mem_read_in = 1; rd_write_in = 1; rd_in = 5'd4; result_in = 32'h3000;
        step();
        stall_in = 1; data_ready_in = 1; data_read_value_in = 32'hCAFE_F00D;
        mid();
        checks++; if ({data_read_out, mem_stall_out} !== 2'b10) begin errors++; $display("FAIL done_complete got %b exp 10", {data_read_out, mem_stall_out}); end
        step();
        data_ready_in = 0; data_read_value_in = 32'h0;
        mid();
        checks++; if (data_read_out !== 1'b0) begin errors++; $display("FAIL done_no_reissue got %b exp 0", data_read_out); end
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL done_hold got %b exp 0", valid_out); end
        stall_in = 0;
        mid();
        checks++; if (data_read_out !== 1'b0) begin errors++; $display("FAIL done_release_strobe got %b exp 0", data_read_out); end
        step();
        $display("txn stalled_load addr=%h rd_value=%h", result_in, rd_value_out);
        checks++; if ({valid_out, rd_value_out} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL done_wb got %b/%h exp 1/cafef00d", valid_out, rd_value_out); end
        idle_inputs();
        step();
    endtask

    task automatic do_branch(input logic [1:0] op, input logic [31:0] res, input logic pred,
                             input logic flush, input logic exp_mis);
        idle_inputs();
        valid_in = 1; branch_op_in = op; result_in = res; branch_predicted_taken_in = pred;
        flush_in = flush; branch_pc_in = 32'h200;
        mid();
        $display("txn branch op=%0d result=%h pred=%0d flush=%0d mis=%0d", op, res, pred, flush, branch_mispredicted_out);
        checks++; if (branch_mispredicted_out !== exp_mis) begin errors++; $display("FAIL branch_mis got %b exp %b", branch_mispredicted_out, exp_mis); end
        checks++; if (branch_pc_out !== 32'h200) begin errors++; $display("FAIL branch_pc got %h exp 00000200", branch_pc_out); end
        step();
    endtask

    task automatic test_branch();
        do_branch(2'd1, 32'h0, 1'b0, 1'b0, 1'b1);
        do_branch(2'd1, 32'h4, 1'b0, 1'b0, 1'b0);
        do_branch(2'd2, 32'h5, 1'b1, 1'b0, 1'b0);
        do_branch(2'd3, 32'h0, 1'b0, 1'b0, 1'b1);
        do_branch(2'd0, 32'h0, 1'b1, 1'b0, 1'b1);
        do_branch(2'd3, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_fence_flush();
        idle_inputs();
        valid_in = 1; mem_fence_in = 1;
        mid();
        checks++; if (fence_out !== 1'b1) begin errors++; $display("FAIL fence_pulse got %b exp 1", fence_out); end
        stall_in = 1;
        #1;
        checks++; if (fence_out !== 1'b0) begin errors++; $display("FAIL fence_stalled got %b exp 0", fence_out); end
        step();
        $display("txn fence");
        idle_inputs();
        valid_in = 1; rd_write_in = 1; rd_in = 5'd2; result_in = 32'h77; flush_in = 1;
        step();
        $display("txn flush");
        checks++; if ({valid_out, rd_write_out} !== 2'b00) begin errors++; $display("FAIL flush_bubble got %b exp 00", {valid_out, rd_write_out}); end
    endtask

    task automatic test_reset_busy();
        idle_inputs();
        valid_in = 1; mem_read_in = 1; rd_write_in = 1; result_in = 32'h4000;
        step();
        reset = 1;
        mid();
        checks++; if ({data_read_out, mem_stall_out} !== 2'b00) begin errors++; $display("FAIL rst_busy_strobe got %b exp 00", {data_read_out, mem_stall_out}); end
        step();
        checks++; if ({valid_out, rd_value_out} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rst_busy_out got %b/%h exp 0/0", valid_out, rd_value_out); end
        reset = 0; valid_in = 0;
        mid();
        checks++; if (data_read_out !== 1'b0) begin errors++; $display("FAIL rst_busy_abandon got %b exp 0", data_read_out); end
        $display("txn reset_in_busy");
        step();
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_passthrough();
        test_wait_states();
        test_stall_done();
        test_branch();
        test_fence_flush();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_mem.md
# rv32_mem

Memory-access and branch-resolution stage of the rv32 pipeline, directly downstream of execute and upstream of writeback. It issues load/store requests on the data bus using the execute result as address, extracts and extends load data, and resolves branches against the execute result, redirecting fetch on mispredict. A small request state machine holds the bus request across wait states and prevents re-issue while the stage is stalled.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall_in / flush_in  in  1 each  from hazard; flush_in kills the instruction presented this cycle
- branch_predicted_taken_in, valid_in, mem_read_in, mem_write_in, mem_zero_extend_in, mem_fence_in, rd_write_in  in  1 each  execute control
- mem_width_in  in  2  0=byte, 1=half, 2=word
- branch_op_in  in  2  NEVER, ZERO, NON_ZERO, ALWAYS
- rd_in  in  5  destination register
- result_in, rs2_value_in, branch_pc_in  in  32 each  execute data
- data_address_out  out  32  word-aligned address ({result_in[31:2],2'b0})
- data_read_out, data_write_out  out  1 each  bus request strobes
- data_write_mask_out  out  4  byte enables
- data_write_value_out  out  32  lane-replicated store data
- data_read_value_in  in  32  load data, valid when data_ready_in
- data_ready_in  in  1  request completes this cycle
- mem_stall_out  out  1  request outstanding and not ready
- branch_mispredicted_out  out  1  combinational redirect to fetch
- branch_pc_out  out  32  redirect target (= branch_pc_in)
- fence_out  out  1  combinational pulse for instruction-fetch flush
- valid_out, rd_write_out  out  1 each  to writeback
- rd_out  out  5, rd_value_out  out  32  to writeback

## Operation
- live = valid_in & !flush_in. Request = live & (mem_read_in|mem_write_in) & state==IDLE.
- FSM: IDLE -> BUSY when request & !data_ready_in; BUSY -> IDLE on data_ready_in & !stall_in; BUSY -> DONE on data_ready_in & stall_in; DONE -> IDLE when !stall_in. Strobes asserted in IDLE (when request) and BUSY; never in DONE.
- flush_in while BUSY: strobes held until data_ready_in (no abandonment); result discarded, bubble written.
- mem_stall_out = strobe asserted & !data_ready_in.
- Store mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. Value: byte replicated x4, half x2.
- Load: shift data_read_value_in right by addr[1:0]*8; sign- or zero-extend per mem_zero_extend_in; word unmodified. DONE state uses a captured copy of the load data.
- Branch: taken = ALWAYS | (ZERO & result==0) | (NON_ZERO & result!=0); branch_mispredicted_out = live & (taken != branch_predicted_taken_in), suppressed while mem_stall_out.
- fence_out = live & mem_fence_in & !stall_in.
- rd_value_out = load value if mem_read_in else result_in.

## Timing
- Zero-wait bus: request and completion same cycle; output register updates next edge.
- Output register updates when !stall_in & !mem_stall_out; on mem_stall_out or flush_in it loads a bubble (valid_out=0, rd_write_out=0).
- Reset: state IDLE, all outputs 0 (valid_out, rd_write_out, rd_out, rd_value_out); strobes drop same cycle; outstanding bus transaction abandoned.

## Configuration
- RV32_MEM_MISALIGNED_TRAP_EN: defined -> half with addr[0]=1 or word with addr[1:0]!=0 issues no request, raises misaligned_out (extra 1-bit output) for one cycle and writes a bubble. Undefined -> no port; low address bits beyond access size are ignored (access aligned down).

## Structure
- Shared package: RV32_BRANCH_OP_* encodings, mem width encodings, FSM state enum.
- One sub-module: rv32_mem_align (combinational mask/replication/extract-extend).

## Test plan
- Word store, result=0x1000, rs2=0xDEADBEEF, ready same cycle -> mask 4'b1111, value 0xDEADBEEF, no stall.
- Byte load signed, addr 0x1003, read 0x80000000 -> rd_value_out 0xFFFFFF80; zero-extend -> 0x00000080.
- Load with ready delayed 3 cycles -> mem_stall_out high 3 cycles, strobe held, one valid writeback.
- Ready while stall_in=1 for 2 cycles -> FSM DONE, no re-issue, captured data written when stall drops.
- branch_op ZERO, result 0, predicted not-taken, branch_pc 0x200 -> branch_mispredicted_out=1, branch_pc_out 0x200.
- Reset asserted in BUSY -> strobes low same cycle, valid_out 0 after edge.
